// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter.
// Loads a W-bit pattern plus a repeat count over a valid/ready handshake.
// It then shifts the pattern out MSB-first on dout/dout_vld, (rep+1) times,
// and obeys backpressure on dout_rdy. GAP bubble slots can be placed between
// repetitions. A one-cycle done pulse follows the last bit.
// Optional build macro: SEQ_GEN_FILL_EN. When it is defined, the transmitter
// sends a PRBS-7 filler stream with dout_vld=1 whenever it is not shifting
// the pattern.
module seq_gen #(
    parameter int W     = 6,
    parameter int REP_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pat_vld,
    output logic             pat_rdy,
    input  logic [W-1:0]     pat,
    input  logic [REP_W-1:0] rep,
    output logic             dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = (W > 1) ? $clog2(W) : 1;
    // The gap counter runs from 0 to GAP-1, so it needs at least one bit.
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [W-1:0]       pat_q;      // pattern frozen from load until DONE
    logic [REP_W-1:0]   rep_cnt;    // repetitions still owed after this one
    logic [BIT_W-1:0]   bit_cnt;    // index of the bit on dout
    logic [GAP_W-1:0]   gap_cnt;    // bubble slots already spent

    logic load;
    logic xfer;
    logic last_bit;
    logic gap_last;
    logic gap_step;                 // one gap slot is used up this cycle

    assign load     = pat_vld & pat_rdy;
    assign xfer     = dout_vld & dout_rdy;
    assign last_bit = (bit_cnt == '0);
    assign gap_last = (gap_cnt == GAP_W'(GAP - 1));

`ifdef SEQ_GEN_FILL_EN
    logic [6:0] lfsr;

    // The filler LFSR advances only when a filler bit is consumed.
    // It is frozen while the pattern is shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 7'h7F;
        end else if (state != S_SHIFT && dout_rdy) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

    // Load is accepted only when the filler bit on the line is consumed too.
    assign pat_rdy  = (state == S_IDLE) & dout_rdy;
    assign gap_step = dout_rdy;
`else
    assign pat_rdy  = (state == S_IDLE);
    assign gap_step = 1'b1;
`endif

    // State register.
    // NOTE: every clocked process uses non-blocking (<=) assignments so that
    // all registers update together from their values before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // NOTE: state_nxt gets a default before the case statement, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (load) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (xfer && last_bit) begin
                    if (rep_cnt == '0)  state_nxt = S_DONE;
                    else if (GAP > 0)   state_nxt = S_GAP;
                    else                state_nxt = S_SHIFT;
                end
            end
            S_GAP: begin
                if (gap_step && gap_last) state_nxt = S_SHIFT;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch the pattern, step through the bits, count repeats and gap slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= '0;
            rep_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (load) begin
                        pat_q   <= pat;
                        rep_cnt <= rep;
                        bit_cnt <= BIT_W'(W - 1);
                    end
                end
                S_SHIFT: begin
                    if (xfer) begin
                        if (last_bit) begin
                            bit_cnt <= BIT_W'(W - 1);
                            gap_cnt <= '0;
                            if (rep_cnt != '0) rep_cnt <= rep_cnt - 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_step) gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output decode. All outputs come from registered state, so reset clears them at once.
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        dout     = 1'b0;
        dout_vld = 1'b0;
        if (state == S_SHIFT) begin
            dout     = pat_q[bit_cnt];
            dout_vld = 1'b1;
        end else begin
`ifdef SEQ_GEN_FILL_EN
            dout     = lfsr[6];
            dout_vld = ~rst;
`endif
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: self-checking bench for seq_gen.
// It instantiates two copies that share their inputs: one with GAP=0 and one
// with GAP=2. Each copy is checked every cycle against a transaction-level
// model. The model keeps a list of output slots (bit, gap bubble, done) that
// is expanded from the loaded pattern and repeat count.
module tb_seq_gen;

    localparam int W     = 6;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             pat_vld;
    logic [W-1:0]     pat;
    logic [REP_W-1:0] rep;
    logic             dout_rdy;
    logic [1:0]       pat_rdy, dout, dout_vld, busy, done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_gen #(.W(W), .REP_W(REP_W), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .pat_vld(pat_vld), .pat_rdy(pat_rdy[0]),
        .pat(pat), .rep(rep), .dout(dout[0]), .dout_vld(dout_vld[0]),
        .dout_rdy(dout_rdy), .busy(busy[0]), .done(done[0])
    );

    seq_gen #(.W(W), .REP_W(REP_W), .GAP(2)) u_dut1 (
        .clk(clk), .rst(rst), .pat_vld(pat_vld), .pat_rdy(pat_rdy[1]),
        .pat(pat), .rep(rep), .dout(dout[1]), .dout_vld(dout_vld[1]),
        .dout_rdy(dout_rdy), .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    // ---------------- transaction-level reference model ----------------
    localparam int K_BIT  = 0;
    localparam int K_GAP  = 1;
    localparam int K_DONE = 2;

    int   m_kind [2][256];
    logic m_bit  [2][256];
    int   m_head [2];
    int   m_tail [2];

    task automatic m_load(input int i, input logic [W-1:0] p, input logic [REP_W-1:0] r);
        m_head[i] = 0;
        m_tail[i] = 0;
        for (int t = 0; t <= int'(r); t++) begin
            for (int b = W - 1; b >= 0; b--) begin
                m_kind[i][m_tail[i]] = K_BIT;
                m_bit[i][m_tail[i]]  = p[b];
                m_tail[i]++;
            end
            if (t < int'(r)) begin
                for (int g = 0; g < gap_of(i); g++) begin
                    m_kind[i][m_tail[i]] = K_GAP;
                    m_bit[i][m_tail[i]]  = 1'b0;
                    m_tail[i]++;
                end
            end
        end
        m_kind[i][m_tail[i]] = K_DONE;
        m_bit[i][m_tail[i]]  = 1'b0;
        m_tail[i]++;
    endtask

    initial begin
        m_head = '{0, 0};
        m_tail = '{0, 0};
    end

    // The model takes one step per clock edge. Bit slots are consumed only on
    // transfer; gap and done slots are consumed every cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_head[i] = 0;
                m_tail[i] = 0;
            end else if (m_head[i] == m_tail[i]) begin
                if (pat_vld) m_load(i, pat, rep);
            end else if (m_kind[i][m_head[i]] != K_BIT || dout_rdy) begin
                m_head[i]++;
            end
        end
    end

`ifndef SEQ_GEN_FILL_EN
    // Compare every output of both copies against the model in the middle of each cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic e_rdy, e_vld, e_dout, e_busy, e_done;
            e_rdy = 1'b1; e_vld = 1'b0; e_dout = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            if (!rst && m_head[i] != m_tail[i]) begin
                e_rdy  = 1'b0;
                e_busy = 1'b1;
                if (m_kind[i][m_head[i]] == K_BIT) begin
                    e_vld  = 1'b1;
                    e_dout = m_bit[i][m_head[i]];
                end else if (m_kind[i][m_head[i]] == K_DONE) begin
                    e_done = 1'b1;
                end
            end
            check($sformatf("model_pat_rdy%0d", i),  32'(pat_rdy[i]),  32'(e_rdy));
            check($sformatf("model_dout_vld%0d", i), 32'(dout_vld[i]), 32'(e_vld));
            check($sformatf("model_dout%0d", i),     32'(dout[i]),     32'(e_dout));
            check($sformatf("model_busy%0d", i),     32'(busy[i]),     32'(e_busy));
            check($sformatf("model_done%0d", i),     32'(done[i]),     32'(e_done));
        end
    end
`endif

    // ---------------- directed-run recording ----------------
    logic rec_vld  [2][256];
    logic rec_dout [2][256];
    logic rec_done [2][256];
    logic rec_busy [2][256];
    logic rec_rdy  [2][256];
    logic cap_bit  [2][256];
    int   cap_n    [2];

    // Wait until both copies are idle. Called and returns at posedge+2.
    task automatic wait_idle();
        int n = 0;
        pat_vld  = 1'b0;
        dout_rdy = 1'b1;
        while (pat_rdy !== 2'b11 && n < 600) begin
            @(posedge clk); #2;
            n++;
        end
        check("wait_idle_timeout", 32'(pat_rdy), 32'(2'b11));
    endtask

    // Load p/r at edge N and record cycles N+1..N+n.
    // dout_rdy is low during cycle N+k when lo_mask[k] is set.
    task automatic run_directed(input logic [W-1:0] p, input logic [REP_W-1:0] r,
                                input logic [255:0] lo_mask, input int n);
        wait_idle();
        pat     = p;
        rep     = r;
        pat_vld = 1'b1;
        @(posedge clk); #2;
        pat_vld = 1'b0;
        pat     = W'($urandom);
        rep     = REP_W'($urandom);
        cap_n   = '{0, 0};
        for (int k = 1; k <= n; k++) begin
            dout_rdy = ~lo_mask[k];
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                rec_vld[i][k]  = dout_vld[i];
                rec_dout[i][k] = dout[i];
                rec_done[i][k] = done[i];
                rec_busy[i][k] = busy[i];
                rec_rdy[i][k]  = pat_rdy[i];
                if (dout_vld[i] && dout_rdy) begin
                    cap_bit[i][cap_n[i]] = dout[i];
                    cap_n[i]++;
                end
            end
            @(posedge clk); #2;
        end
        dout_rdy = 1'b1;
    endtask

    // Check the bits captured by copy i against pattern p sent reps times.
    task automatic check_capture(input string name, input int i, input logic [W-1:0] p, input int reps);
        check({name, "_count"}, 32'(cap_n[i]), 32'(W * reps));
        for (int j = 0; j < W * reps && j < cap_n[i]; j++)
            check($sformatf("%s_bit%0d", name, j), 32'(cap_bit[i][j]), 32'(p[W - 1 - (j % W)]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] p;
        int           ndone;
        rst      = 1'b1;
        pat_vld  = 1'b0;
        pat      = '0;
        rep      = '0;
        dout_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_pat_rdy",  32'(pat_rdy),  32'(2'b11));
        check("reset_dout_vld", 32'(dout_vld), 32'(2'b00));
        check("reset_dout",     32'(dout),     32'(2'b00));
        check("reset_busy",     32'(busy),     32'(2'b00));
        check("reset_done",     32'(done),     32'(2'b00));
        rst = 1'b0;

`ifdef SEQ_GEN_FILL_EN
        // The PRBS-7 filler from seed 7'h7F gives seven ones, then a zero.
        p = '0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] e;
            e = 8'b1111_1110;
            @(negedge clk);
            check($sformatf("fill_vld%0d", k), 32'(dout_vld[0]), 32'(1));
            check($sformatf("fill_bit%0d", k), 32'(dout[0]),     32'(e[7 - k]));
        end
        @(posedge clk); #2;
`else
        // 1: 111000, rep 0, sink always ready.
        p = 6'b111000;
        run_directed(p, 4'd0, 256'd0, 10);
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("t1_vld%0d", k), 32'(rec_vld[0][k]),  32'(1));
            check($sformatf("t1_bit%0d", k), 32'(rec_dout[0][k]), 32'(p[6 - k]));
            check($sformatf("t1_nodone%0d", k), 32'(rec_done[0][k]), 32'(0));
        end
        check("t1_done7",   32'(rec_done[0][7]), 32'(1));
        check("t1_vld7",    32'(rec_vld[0][7]),  32'(0));
        check("t1_busy7",   32'(rec_busy[0][7]), 32'(1));
        check("t1_done8",   32'(rec_done[0][8]), 32'(0));
        check("t1_rdy7",    32'(rec_rdy[0][7]),  32'(0));
        check("t1_rdy8",    32'(rec_rdy[0][8]),  32'(1));

        // 2: 101110, sink stalls during cycles N+2 and N+3.
        p = 6'b101110;
        run_directed(p, 4'd0, 256'b1100, 12);
        for (int k = 2; k <= 4; k++) begin
            check($sformatf("t2_hold_vld%0d", k), 32'(rec_vld[0][k]),  32'(1));
            check($sformatf("t2_hold_bit%0d", k), 32'(rec_dout[0][k]), 32'(0));
        end
        check("t2_done8", 32'(rec_done[0][8]), 32'(0));
        check("t2_done9", 32'(rec_done[0][9]), 32'(1));
        check_capture("t2_cap", 0, p, 1);

        // 3: 101110, rep 2, GAP=0: 18 back-to-back bits and a single done.
        run_directed(p, 4'd2, 256'd0, 24);
        ndone = 0;
        for (int k = 1; k <= 24; k++) ndone += int'(rec_done[0][k]);
        for (int k = 1; k <= 18; k++)
            check($sformatf("t3_vld%0d", k), 32'(rec_vld[0][k]), 32'(1));
        check("t3_done19",  32'(rec_done[0][19]), 32'(1));
        check("t3_ndone",   32'(ndone),           32'(1));
        check_capture("t3_cap", 0, p, 3);

        // 4: GAP=2 copy, rep 1: 6 bits, 2 bubbles, 6 bits, done. Busy stays high throughout.
        p = 6'b110100;
        run_directed(p, 4'd1, 256'd0, 18);
        for (int k = 1; k <= 15; k++) begin
            logic ev;
            ev = (k <= 6) || (k >= 9 && k <= 14);
            check($sformatf("t4_vld%0d", k),  32'(rec_vld[1][k]),  32'(ev));
            check($sformatf("t4_busy%0d", k), 32'(rec_busy[1][k]), 32'(1));
        end
        check("t4_done15", 32'(rec_done[1][15]), 32'(1));
        check("t4_done14", 32'(rec_done[1][14]), 32'(0));
        check_capture("t4_cap", 1, p, 2);

        // 5: reset arrives while the third bit is valid.
        wait_idle();
        pat = 6'b111000; rep = 4'd3; pat_vld = 1'b1;
        @(posedge clk); #2;
        pat_vld = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
        check("t5_pre_vld", 32'(dout_vld[0]), 32'(1));
        rst = 1'b1;
        #1;
        check("t5_vld_async",  32'(dout_vld), 32'(2'b00));
        check("t5_busy_async", 32'(busy),     32'(2'b00));
        @(posedge clk); #2;
        rst = 1'b0;
        check("t5_rdy_after", 32'(pat_rdy), 32'(2'b11));
        ndone = 0;
        repeat (4) begin @(negedge clk); ndone += int'(done[0]) + int'(done[1]); end
        check("t5_no_done", 32'(ndone), 32'(0));
        @(posedge clk); #2;
        p = 6'b111000;
        run_directed(p, 4'd0, 256'd0, 9);
        check_capture("t5_reload", 0, p, 1);
        check("t5_reload_done7", 32'(rec_done[0][7]), 32'(1));

        // Boundary: rep at its maximum value gives 16 transmissions.
        p = W'($urandom);
        run_directed(p, 4'hF, 256'd0, 130);
        check_capture("tmax_cap0", 0, p, 16);
        check_capture("tmax_cap1", 1, p, 16);
        check("tmax_done0_97",  32'(rec_done[0][97]),  32'(1));
        check("tmax_done1_127", 32'(rec_done[1][127]), 32'(1));

        // Random traffic: noisy pat_vld, random backpressure, occasional reset.
        for (int c = 0; c < 4000; c++) begin
            pat_vld  = ($urandom_range(0, 3) == 0);
            pat      = W'($urandom);
            rep      = ($urandom_range(0, 7) == 0) ? 4'hF : REP_W'($urandom_range(0, 3));
            dout_rdy = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 599) == 0);
            @(posedge clk); #2;
        end
        rst     = 1'b0;
        pat_vld = 1'b0;
        wait_idle();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
